reg_file_dual_wb: RTL and testbench

REG_FILE_DUAL_WB -- requirements
Module: reg_file_dual_wb

---
 rtl/reg_file_dual_wb_if.sv | 42 ++++
 rtl/reg_file_dual_wb.sv | 145 ++++++++++++++
 tb/tb_reg_file_dual_wb.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_dual_wb_if.sv
// Bus bundle for the dual-writeback register file: two read ports, two
// write ports, the issue-time busy marker and the ready/pending status.
//
// Handshake: ready is the only flow-control signal. While ready is low the
// block is clearing its registers; wrt_en0, wrt_en1 and busy_set are ignored
// and every read output is forced to 0. While ready is high, each enabled
// write or busy_set presented before a rising edge is taken at that edge, and
// no back-pressure exists (ready never drops in RUN except through rst).
interface reg_file_dual_wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] data_a;
    logic [DATA_WIDTH-1:0] data_b;
    logic                  wrt_en0;
    logic [ADDR_WIDTH-1:0] addr_d0;
    logic [DATA_WIDTH-1:0] d0;
    logic                  wrt_en1;
    logic [ADDR_WIDTH-1:0] addr_d1;
    logic [DATA_WIDTH-1:0] d1;
    logic                  busy_set;
    logic [ADDR_WIDTH-1:0] busy_addr;
    logic                  pend_a;
    logic                  pend_b;

    // The register file itself.
    modport slave (
        output ready, data_a, data_b, pend_a, pend_b,
        input  addr_a, addr_b, wrt_en0, addr_d0, d0,
        input  wrt_en1, addr_d1, d1, busy_set, busy_addr
    );

    // The pipeline that issues, writes back and reads operands.
    modport master (
        input  ready, data_a, data_b, pend_a, pend_b,
        output addr_a, addr_b, wrt_en0, addr_d0, d0,
        output wrt_en1, addr_d1, d1, busy_set, busy_addr
    );
endinterface

// File: rtl/reg_file_dual_wb.sv
// Register file with two combinational read ports, two writeback ports
// (ALU on port 0, memory on port 1) with write-to-read bypass, and a per-
// register busy scoreboard. After reset the registers are zeroed one per
// clock (CLEAR) before the block reports ready (RUN).
module reg_file_dual_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int NREG       = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    reg_file_dual_wb_if.slave  bus,
    output logic               dbg_state
);
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NREG - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_CLR = ADDR_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]       busy;

    logic run;
    logic wr0;
    logic wr1;
    logic hit0_a;
    logic hit1_a;
    logic hit0_b;
    logic hit1_b;

    // Writes only count in RUN and never to register 0.
    assign run = (state == RUN);
    assign wr0 = run && bus.wrt_en0 && (bus.addr_d0 != '0);
    assign wr1 = run && bus.wrt_en1 && (bus.addr_d1 != '0);

    assign hit0_a = wr0 && (bus.addr_d0 == bus.addr_a);
    assign hit1_a = wr1 && (bus.addr_d1 == bus.addr_a);
    assign hit0_b = wr0 && (bus.addr_d0 == bus.addr_b);
    assign hit1_b = wr1 && (bus.addr_d1 == bus.addr_b);

    assign bus.ready = run;
    assign dbg_state = state;

    // State register: reset always restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR on the edge that zeroes the last register.
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_ptr == LAST_REG) begin
            state_nxt = RUN;
        end
    end

    // Clear pointer: starts at 1 because register 0 is hardwired to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr <= FIRST_CLR;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + FIRST_CLR;
        end
    end

    // Register array: one clear write per edge in CLEAR, writebacks in RUN;
    // port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_ptr] <= '0;
            end else begin
                if (wr0) begin
                    regs[bus.addr_d0] <= bus.d0;
                end
                if (wr1) begin
                    regs[bus.addr_d1] <= bus.d1;
                end
            end
        end
    end

    // Busy scoreboard: writeback clears, issue sets, and set is applied last
    // so an issue in the same cycle as a writeback keeps the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            if (run) begin
                for (int i = 1; i < NREG; i++) begin
                    if ((wr0 && bus.addr_d0 == ADDR_WIDTH'(i)) ||
                        (wr1 && bus.addr_d1 == ADDR_WIDTH'(i))) begin
                        busy[i] <= 1'b0;
                    end
                    if (bus.busy_set && bus.busy_addr == ADDR_WIDTH'(i)) begin
                        busy[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Read port A: bypass from port 1 then port 0, else stored value.
    always_comb begin
        bus.data_a = '0;
        bus.pend_a = 1'b0;
        if (run && bus.addr_a != '0) begin
            if (hit1_a) begin
                bus.data_a = bus.d1;
            end else if (hit0_a) begin
                bus.data_a = bus.d0;
            end else begin
                bus.data_a = regs[bus.addr_a];
            end
            bus.pend_a = busy[bus.addr_a] && !hit0_a && !hit1_a;
        end
    end

    // Read port B: same structure as port A.
    always_comb begin
        bus.data_b = '0;
        bus.pend_b = 1'b0;
        if (run && bus.addr_b != '0) begin
            if (hit1_b) begin
                bus.data_b = bus.d1;
            end else if (hit0_b) begin
                bus.data_b = bus.d0;
            end else begin
                bus.data_b = regs[bus.addr_b];
            end
            bus.pend_b = busy[bus.addr_b] && !hit0_b && !hit1_b;
        end
    end
endmodule

// File: tb/tb_reg_file_dual_wb.sv
// Directed bench for reg_file_dual_wb. Drivers set inputs 1 time unit after
// a rising edge and queue the expected outputs; the monitor drains the queue
// on each falling edge and compares against the live DUT outputs.
module tb_reg_file_dual_wb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int EW = 35;  // {kind[1:0], pend, data[31:0]}

    localparam logic [1:0] K_A     = 2'd0;
    localparam logic [1:0] K_B     = 2'd1;
    localparam logic [1:0] K_READY = 2'd2;

    logic clk;
    logic rst;
    logic dbg_state;

    int total;
    int bad;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];

    reg_file_dual_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_file_dual_wb #(
        .DATA_WIDTH(DW),
        .NREG      (NR),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input string nm, input logic [DW-1:0] d, input logic p);
        exp_q.push_back({K_A, p, d});
        name_q.push_back(nm);
    endtask

    task automatic exp_b(input string nm, input logic [DW-1:0] d, input logic p);
        exp_q.push_back({K_B, p, d});
        name_q.push_back(nm);
    endtask

    task automatic exp_ready(input string nm, input logic r);
        exp_q.push_back({K_READY, 1'b0, {{(DW-1){1'b0}}, r}});
        name_q.push_back(nm);
    endtask

    task automatic idle_inputs();
        bus.addr_a    = '0;
        bus.addr_b    = '0;
        bus.wrt_en0   = 1'b0;
        bus.addr_d0   = '0;
        bus.d0        = '0;
        bus.wrt_en1   = 1'b0;
        bus.addr_d1   = '0;
        bus.d1        = '0;
        bus.busy_set  = 1'b0;
        bus.busy_addr = '0;
    endtask

    // Clear sequence: ready must stay low for 31 edges and rise after the 31st.
    task automatic check_clear(input string nm);
        for (int k = 0; k < NR - 1; k++) begin
            exp_ready(nm, 1'b0);
            exp_a({nm, "_rd_a"}, '0, 1'b0);
            exp_b({nm, "_rd_b"}, '0, 1'b0);
            step();
        end
        exp_ready({nm, "_done"}, 1'b1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        string         nm;
        logic [DW-1:0] act_d;
        logic          act_p;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (e[EW-1 -: 2])
                K_A: begin
                    act_d = bus.data_a;
                    act_p = bus.pend_a;
                end
                K_B: begin
                    act_d = bus.data_b;
                    act_p = bus.pend_b;
                end
                default: begin
                    act_d = {{(DW-1){1'b0}}, bus.ready};
                    act_p = 1'b0;
                end
            endcase
            total++;
            if (act_d !== e[DW-1:0] || act_p !== e[DW]) begin
                bad++;
                $display("FAIL %s: got data=%h pend=%b, want data=%h pend=%b",
                         nm, act_d, act_p, e[DW-1:0], e[DW]);
            end
        end
    end

    // Directed stimulus.
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();

        // Two reset edges; outputs masked while held.
        step();
        exp_ready("rst_ready", 1'b0);
        exp_a("rst_data_a", '0, 1'b0);
        step();
        rst = 1'b0;

        // Writes and busy_set during CLEAR must be ignored; bypass masked too.
        bus.wrt_en0   = 1'b1;
        bus.addr_d0   = 5'd5;
        bus.d0        = 32'hFFFF_FFFF;
        bus.busy_set  = 1'b1;
        bus.busy_addr = 5'd7;
        bus.addr_a    = 5'd5;
        bus.addr_b    = 5'd7;
        check_clear("clear1");
        idle_inputs();
        step();

        // Every register reads 0 with nothing pending after clear.
        for (int i = 0; i < NR; i++) begin
            bus.addr_a = AW'(i);
            exp_a($sformatf("zero_r%0d", i), '0, 1'b0);
            step();
        end

        // Register 0 write is dropped, no bypass either.
        bus.wrt_en0 = 1'b1;
        bus.addr_d0 = 5'd0;
        bus.d0      = 32'h0000_4541;
        bus.addr_a  = 5'd0;
        exp_a("r0_same_cycle", '0, 1'b0);
        step();
        idle_inputs();
        exp_a("r0_after_edge", '0, 1'b0);
        step();

        // Same-address collision: port 1 wins bypass and storage.
        bus.wrt_en0 = 1'b1;
        bus.addr_d0 = 5'd6;
        bus.d0      = 32'hAAAA_0000;
        bus.wrt_en1 = 1'b1;
        bus.addr_d1 = 5'd6;
        bus.d1      = 32'h5555_1111;
        bus.addr_a  = 5'd6;
        bus.addr_b  = 5'd6;
        exp_a("coll_bypass_a", 32'h5555_1111, 1'b0);
        exp_b("coll_bypass_b", 32'h5555_1111, 1'b0);
        step();
        idle_inputs();
        bus.addr_a = 5'd6;
        exp_a("coll_stored", 32'h5555_1111, 1'b0);
        step();

        // Two different registers written in the same cycle.
        bus.wrt_en0 = 1'b1;
        bus.addr_d0 = 5'd9;
        bus.d0      = 32'h0000_0099;
        bus.wrt_en1 = 1'b1;
        bus.addr_d1 = 5'd10;
        bus.d1      = 32'h0000_1010;
        bus.addr_a  = 5'd9;
        bus.addr_b  = 5'd10;
        exp_a("dual_bypass0", 32'h0000_0099, 1'b0);
        exp_b("dual_bypass1", 32'h0000_1010, 1'b0);
        step();
        idle_inputs();
        bus.addr_a = 5'd9;
        bus.addr_b = 5'd10;
        exp_a("dual_stored0", 32'h0000_0099, 1'b0);
        exp_b("dual_stored1", 32'h0000_1010, 1'b0);
        step();

        // Busy scoreboard on register 3.
        bus.busy_set  = 1'b1;
        bus.busy_addr = 5'd3;
        bus.addr_b    = 5'd3;
        exp_b("busy_issue_cycle", '0, 1'b0);
        step();
        bus.busy_set = 1'b0;
        exp_b("busy_pending", '0, 1'b1);
        step();
        bus.wrt_en1 = 1'b1;
        bus.addr_d1 = 5'd3;
        bus.d1      = 32'h0000_1234;
        exp_b("busy_wb_bypass", 32'h0000_1234, 1'b0);
        step();
        bus.wrt_en1 = 1'b0;
        exp_b("busy_wb_cleared", 32'h0000_1234, 1'b0);
        step();
        bus.busy_set  = 1'b1;
        bus.busy_addr = 5'd3;
        bus.wrt_en0   = 1'b1;
        bus.addr_d0   = 5'd3;
        bus.d0        = 32'h0000_5678;
        exp_b("set_and_wb_cycle", 32'h0000_5678, 1'b0);
        step();
        idle_inputs();
        bus.addr_b = 5'd3;
        exp_b("set_wins", 32'h0000_5678, 1'b1);
        step();

        // busy_set on register 0 never makes it pending.
        bus.busy_set  = 1'b1;
        bus.busy_addr = 5'd0;
        step();
        idle_inputs();
        exp_a("r0_never_busy", '0, 1'b0);
        step();

        // Reset in RUN with a write in flight, then reset again at clear step 10.
        bus.wrt_en1 = 1'b1;
        bus.addr_d1 = 5'd12;
        bus.d1      = 32'h0000_ABCD;
        rst         = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.busy_set  = 1'b1;
        bus.busy_addr = 5'd3;
        bus.addr_a    = 5'd12;
        bus.addr_b    = 5'd3;
        check_clear("clear2");
        idle_inputs();
        step();
        bus.addr_a = 5'd12;
        bus.addr_b = 5'd3;
        exp_a("rst_discard_wr", '0, 1'b0);
        exp_b("rst_busy_cleared", '0, 1'b0);
        step();
        bus.addr_a = 5'd6;
        bus.addr_b = 5'd9;
        exp_a("reclear_r6", '0, 1'b0);
        exp_b("reclear_r9", '0, 1'b0);
        step();
        step();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
